jtag_axi_dispatch: RTL and testbench

JTAG_AXI_DISPATCH -- requirements
Module: jtag_axi_dispatch

---
 rtl/jtag_axi_dispatch.sv | 229 ++++++++++++++++++++++
 tb/tb_jtag_axi_dispatch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_axi_dispatch.sv
`default_nettype none
// jtag_axi_dispatch: issues one AXI4-Lite read or write per dispatch pulse and reports the response.
// Optional in-flight timeout with response draining is enabled by defining JTAG_AXI_TIMEOUT_EN.
module jtag_axi_dispatch #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        trstn,
   input  logic        dispatch_i,
   input  logic        status_ack_i,
   input  logic        txn_write_i,
   input  logic [1:0]  txn_size_i,
   input  logic [31:0] txn_addr_i,
   input  logic [31:0] txn_wdata_i,
   output logic [31:0] rdata_o,
   output logic [2:0]  status_o,
   output logic        busy_o,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_RESP = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RUNNING = 3'd1;
   localparam logic [2:0] ST_OKAY    = 3'd2;
   localparam logic [2:0] ST_TIMEOUT = 3'd6;

   generate
      if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
         $error("jtag_axi_dispatch: TIMEOUT_CYCLES must be within 2..65535");
      end
   endgenerate

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  status_q, status_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        arvalid_q, arvalid_d;
   logic        dispatch_ok;
   logic        in_flight;
   logic        aw_done, w_done;
   logic [3:0]  strb_base;
   logic        timeout;
   logic        drain_q;

   assign in_flight   = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                        (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
   assign dispatch_ok = dispatch_i && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef JTAG_AXI_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        drain_d;

   assign timeout = in_flight && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

   // Drain stays armed from a timeout until the next dispatch so late beats are swallowed.
   always_comb begin
      cnt_d   = cnt_q;
      drain_d = drain_q;
      if (dispatch_ok) begin
         cnt_d   = 16'd0;
         drain_d = 1'b0;
      end else if (timeout) begin
         drain_d = 1'b1;
      end else if (in_flight) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge trstn) begin
      if (!trstn) begin
         cnt_q   <= 16'd0;
         drain_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end
`else
   assign timeout = 1'b0;
   assign drain_q = 1'b0;
`endif

   always_comb begin
      case (txn_size_i)
         2'd0:    strb_base = 4'b0001;
         2'd1:    strb_base = 4'b0011;
         default: strb_base = 4'b1111;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      status_d  = status_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      aw_done   = !awvalid_q || m_axi_awready;
      w_done    = !wvalid_q || m_axi_wready;

      if (dispatch_ok) begin
         addr_d    = txn_addr_i;
         wdata_d   = txn_wdata_i;
         wstrb_d   = strb_base << txn_addr_i[1:0];
         status_d  = ST_RUNNING;
         awvalid_d = txn_write_i;
         wvalid_d  = txn_write_i;
         arvalid_d = !txn_write_i;
         state_d   = txn_write_i ? S_WR_REQ : S_RD_REQ;
      end else if (timeout) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         arvalid_d = 1'b0;
         status_d  = ST_TIMEOUT;
         state_d   = S_DONE;
      end else begin
         case (state_q)
            S_WR_REQ: begin
               // AW and W retire independently; advance only when both have.
               awvalid_d = awvalid_q && !m_axi_awready;
               wvalid_d  = wvalid_q && !m_axi_wready;
               if (aw_done && w_done) begin
                  state_d = S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (m_axi_bvalid) begin
                  status_d = ST_OKAY + {1'b0, m_axi_bresp};
                  state_d  = S_DONE;
               end
            end
            S_RD_REQ: begin
               if (m_axi_arready) begin
                  arvalid_d = 1'b0;
                  state_d   = S_RD_RESP;
               end
            end
            S_RD_RESP: begin
               if (m_axi_rvalid) begin
                  rdata_d  = m_axi_rdata;
                  status_d = ST_OKAY + {1'b0, m_axi_rresp};
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               if (status_ack_i) begin
                  status_d = ST_IDLE;
                  state_d  = S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge trstn) begin
      if (!trstn) begin
         state_q   <= S_IDLE;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         rdata_q   <= 32'd0;
         status_q  <= ST_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         status_q  <= status_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
      end
   end

   assign rdata_o       = rdata_q;
   assign status_o      = status_q;
   assign busy_o        = in_flight;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = (state_q == S_WR_RESP) || drain_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == S_RD_RESP) || drain_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_axi_dispatch.sv
`default_nettype none
// Bench for jtag_axi_dispatch: table vectors, corner sequences and random transactions vs a byte-lane model.
module tb_jtag_axi_dispatch;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        trstn;
   logic        dispatch_i, status_ack_i, txn_write_i;
   logic [1:0]  txn_size_i;
   logic [31:0] txn_addr_i, txn_wdata_i;
   logic [31:0] rdata_o;
   logic [2:0]  status_o;
   logic        busy_o;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;
   logic [1:0]  m_axi_bresp, m_axi_rresp;

   jtag_axi_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .trstn(trstn), .dispatch_i(dispatch_i), .status_ack_i(status_ack_i),
      .txn_write_i(txn_write_i), .txn_size_i(txn_size_i), .txn_addr_i(txn_addr_i),
      .txn_wdata_i(txn_wdata_i), .rdata_o(rdata_o), .status_o(status_o), .busy_o(busy_o),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
      logic        ack;
      logic        redisp;
      logic [3:0]  exp_wstrb;
      logic [2:0]  exp_status;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_rdata = 32'd0;
   logic        pending = 1'b0;
   vec_t        tbl[9];
   vec_t        rv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte-lane model: enable one bit per byte of the access, starting at the address offset.
   function automatic logic [3:0] model_wstrb(input logic [1:0] size, input logic [31:0] addr);
      int nbytes;
      int m;
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      m = ((1 << nbytes) - 1) << (addr % 4);
      return m[3:0];
   endfunction

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic [1:0] resp, input int aw, input int w, input int b,
                               input int ar, input int r, input logic ack, input logic redisp,
                               input logic [3:0] ewstrb, input logic [2:0] estatus);
      vec_t v;
      v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.resp = resp;
      v.aw_lat = aw; v.w_lat = w; v.b_lat = b; v.ar_lat = ar; v.r_lat = r;
      v.ack = ack; v.redisp = redisp; v.exp_wstrb = ewstrb; v.exp_status = estatus;
      return v;
   endfunction

   // Called at a negedge; returns at the next negedge with the first valid expected up.
   task automatic dispatch(input vec_t v, input logic with_ack);
      dispatch_i = 1'b1; status_ack_i = with_ack;
      txn_write_i = v.wr; txn_size_i = v.size; txn_addr_i = v.addr; txn_wdata_i = v.wdata;
      @(negedge clk);
      dispatch_i = 1'b0; status_ack_i = 1'b0;
      txn_write_i = 1'($urandom); txn_size_i = 2'($urandom); txn_addr_i = $urandom; txn_wdata_i = $urandom;
      chk("busy_after_dispatch", busy_o, 1);
      chk("status_running", status_o, 3'd1);
      chk("first_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, v.wr ? 3'b110 : 3'b001);
   endtask

   task automatic serve(input vec_t v);
      int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
      bit aw_d = 0, w_d = 0, ar_d = 0, fin = 0, stray = 0, redone = 0;
      logic [31:0] g_awaddr = 0, g_wdata = 0, g_araddr = 0;
      logic [3:0]  g_wstrb = 0;
      logic [2:0]  g_prot = 0;
      for (int c = 0; c < 200 && !fin; c++) begin
         dispatch_i = 1'b0;
         if (v.wr) begin
            if (m_axi_arvalid || (m_axi_awvalid && aw_d) || (m_axi_wvalid && w_d)) stray = 1;
            m_axi_bvalid  = aw_d && w_d && (b_c >= v.b_lat);
            m_axi_bresp   = v.resp;
            m_axi_awready = m_axi_awvalid && (aw_c >= v.aw_lat);
            m_axi_wready  = m_axi_wvalid && (w_c >= v.w_lat);
            if (m_axi_awvalid && !m_axi_awready) aw_c++;
            if (m_axi_wvalid && !m_axi_wready) w_c++;
            if (aw_d && w_d && !m_axi_bvalid) b_c++;
            if (m_axi_awvalid && m_axi_awready) begin
               aw_d = 1; g_awaddr = m_axi_awaddr; g_prot |= m_axi_awprot;
            end
            if (m_axi_wvalid && m_axi_wready) begin
               w_d = 1; g_wdata = m_axi_wdata; g_wstrb = m_axi_wstrb;
            end
            if (m_axi_bvalid && m_axi_bready) fin = 1;
         end else begin
            if (m_axi_awvalid || m_axi_wvalid || (m_axi_arvalid && ar_d)) stray = 1;
            m_axi_rvalid  = ar_d && (r_c >= v.r_lat);
            m_axi_rdata   = v.rdata;
            m_axi_rresp   = v.resp;
            m_axi_arready = m_axi_arvalid && (ar_c >= v.ar_lat);
            if (v.redisp && ar_d && !redone) begin
               dispatch_i = 1'b1; txn_write_i = 1'b1; redone = 1;
            end
            if (m_axi_arvalid && !m_axi_arready) ar_c++;
            if (ar_d && !m_axi_rvalid) r_c++;
            if (m_axi_arvalid && m_axi_arready) begin
               ar_d = 1; g_araddr = m_axi_araddr; g_prot |= m_axi_arprot;
            end
            if (m_axi_rvalid && m_axi_rready) fin = 1;
         end
         @(negedge clk);
      end
      dispatch_i = 1'b0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      chk("txn_completed", fin, 1);
      chk("no_stray_valid", stray, 0);
      chk("prot_zero", g_prot, 3'd0);
      if (v.wr) begin
         chk("awaddr", g_awaddr, v.addr);
         chk("wdata", g_wdata, v.wdata);
         chk("wstrb", g_wstrb, v.exp_wstrb);
      end else begin
         chk("araddr", g_araddr, v.addr);
         last_rdata = v.rdata;
      end
      chk("final_status", status_o, v.exp_status);
      chk("final_busy", busy_o, 0);
      chk("rdata_o", rdata_o, last_rdata);
      chk("valids_idle", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
      if (v.ack) begin
         status_ack_i = 1'b1;
         @(negedge clk);
         status_ack_i = 1'b0;
         chk("status_after_ack", status_o, 3'd0);
`ifndef JTAG_AXI_TIMEOUT_EN
         chk("readies_low_idle", {m_axi_bready, m_axi_rready}, 2'b00);
`endif
      end
   endtask

   task automatic run(input vec_t v);
      dispatch(v, pending);
      serve(v);
      pending = !v.ack;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      trstn = 1'b0; dispatch_i = 0; status_ack_i = 0; txn_write_i = 0; txn_size_i = 0;
      txn_addr_i = 0; txn_wdata_i = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;

      //            wr    sz  addr          wdata         rdata         rsp aw w b ar r ack rd  wstrb    st
      tbl[0] = mk(1'b0, 2'd0, 32'h1000_0004, 32'h0,        32'hDEADBEEF, 2'd0, 0,0,0, 0,2, 1'b0,1'b0, 4'b0000, 3'd2);
      tbl[1] = mk(1'b1, 2'd0, 32'h0000_0003, 32'hAABBCCDD, 32'h0,        2'd2, 0,3,1, 0,0, 1'b1,1'b0, 4'b1000, 3'd4);
      tbl[2] = mk(1'b0, 2'd2, 32'h0000_0020, 32'h0,        32'h0BADF00D, 2'd0, 0,0,0, 1,2, 1'b1,1'b1, 4'b0000, 3'd2);
      tbl[3] = mk(1'b1, 2'd1, 32'h0000_0102, 32'h11223344, 32'h0,        2'd1, 2,0,0, 0,0, 1'b0,1'b0, 4'b1100, 3'd3);
      tbl[4] = mk(1'b1, 2'd1, 32'h0000_0003, 32'h55667788, 32'h0,        2'd3, 1,1,2, 0,0, 1'b1,1'b0, 4'b1000, 3'd5);
      tbl[5] = mk(1'b1, 2'd2, 32'h0000_0005, 32'h99AABBCC, 32'h0,        2'd0, 0,0,0, 0,0, 1'b0,1'b0, 4'b1110, 3'd2);
      tbl[6] = mk(1'b1, 2'd3, 32'h0000_0008, 32'h01020304, 32'h0,        2'd0, 3,1,0, 0,0, 1'b1,1'b0, 4'b1111, 3'd2);
      tbl[7] = mk(1'b0, 2'd0, 32'h0000_000C, 32'h0,        32'h13579BDF, 2'd2, 0,0,0, 2,0, 1'b1,1'b0, 4'b0000, 3'd4);
      tbl[8] = mk(1'b0, 2'd1, 32'h8000_0000, 32'h0,        32'hCAFEF00D, 2'd3, 0,0,0, 0,0, 1'b1,1'b0, 4'b0000, 3'd5);

      @(negedge clk); @(negedge clk);
      chk("reset_status", status_o, 3'd0);
      chk("reset_busy_rdata", {busy_o, rdata_o}, 33'd0);
      chk("reset_valids_readies", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'd0);
      chk("reset_latched", {m_axi_awaddr, m_axi_wstrb}, 36'd0);
      trstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run(tbl[i]);

      // Reset while waiting for B: everything drops at once, then a read still works.
      rv = mk(1'b1, 2'd2, 32'h40, 32'h77, 32'h0, 2'd0, 0,0,50, 0,0, 1'b0,1'b0, 4'b1111, 3'd2);
      dispatch(rv, pending);
      m_axi_awready = 1; m_axi_wready = 1;
      @(negedge clk);
      m_axi_awready = 0; m_axi_wready = 0;
      chk("bready_in_wr_resp", m_axi_bready, 1);
      #2 trstn = 1'b0;
      #1;
      chk("midreset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, busy_o}, 6'd0);
      chk("midreset_status", status_o, 3'd0);
      chk("midreset_rdata", rdata_o, 32'd0);
      @(negedge clk);
      trstn = 1'b1; pending = 1'b0; last_rdata = 32'd0;
      @(negedge clk);
      run(mk(1'b0, 2'd2, 32'h1000_0004, 32'h0, 32'h600DF00D, 2'd0, 0,0,0, 0,1, 1'b1,1'b0, 4'b0000, 3'd2));

`ifdef JTAG_AXI_TIMEOUT_EN
      // AW never accepted: TIMEOUT after TO cycles, then late beats are drained silently.
      rv = mk(1'b1, 2'd2, 32'h80, 32'h5A5A5A5A, 32'h0, 2'd0, 0,0,0, 0,0, 1'b0,1'b0, 4'b1111, 3'd6);
      dispatch(rv, pending);
      for (int k = 0; k < TO - 1; k++) @(negedge clk);
      chk("to_not_yet", status_o, 3'd1);
      chk("to_awvalid_held", m_axi_awvalid, 1);
      @(negedge clk);
      chk("to_status", status_o, 3'd6);
      chk("to_valids_drop", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, busy_o}, 4'd0);
      chk("to_drain_readies", {m_axi_bready, m_axi_rready}, 2'b11);
      m_axi_bvalid = 1; m_axi_bresp = 2'd0;
      @(negedge clk);
      m_axi_bvalid = 0; m_axi_rvalid = 1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'd0;
      @(negedge clk);
      m_axi_rvalid = 0;
      chk("to_status_after_drain", status_o, 3'd6);
      chk("to_rdata_unchanged", rdata_o, last_rdata);
      status_ack_i = 1; @(negedge clk); status_ack_i = 0;
      chk("to_ack_idle", status_o, 3'd0);
      chk("to_drain_in_idle", m_axi_bready, 1);
      pending = 1'b0;
`endif

      for (int n = 0; n < 40; n++) begin
         rv.wr = 1'($urandom); rv.size = 2'($urandom); rv.addr = $urandom;
         rv.wdata = $urandom; rv.rdata = $urandom; rv.resp = 2'($urandom);
         rv.aw_lat = $urandom_range(0, 3); rv.w_lat = $urandom_range(0, 3);
         rv.b_lat = $urandom_range(0, 3); rv.ar_lat = $urandom_range(0, 3);
         rv.r_lat = $urandom_range(1, 3); rv.ack = 1'($urandom);
         rv.redisp = !rv.wr && ($urandom_range(0, 3) == 0);
         rv.exp_wstrb = model_wstrb(rv.size, rv.addr);
         rv.exp_status = 3'(2 + int'(rv.resp));
         run(rv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
